// File: rtl/sram_queue_scheduler.sv
// Command sequencer for the shared single-port SRAM holding NUM_QUEUES circular FIFO regions.
// Optional SRAM_SCHED_STATS_EN enables the accepted write/read command counters.
module sram_queue_scheduler #(
    parameter int unsigned NUM_QUEUES     = 4,
    parameter int unsigned QUEUE_ID_WIDTH = 2,
    parameter int unsigned MEM_ADDR_WIDTH = 19,
    parameter int unsigned BURST_LEN      = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cal_done,
    input  logic [NUM_QUEUES-1:0]     wr_req,
    input  logic [NUM_QUEUES-1:0]     rd_req,
    output logic [NUM_QUEUES-1:0]     wr_pop,
    output logic [NUM_QUEUES-1:0]     rd_issue,
    output logic                      mem_cmd_valid,
    input  logic                      mem_cmd_ready,
    output logic                      mem_cmd_we,
    output logic [MEM_ADDR_WIDTH-1:0] mem_cmd_addr,
    output logic [QUEUE_ID_WIDTH-1:0] mem_cmd_qid,
    output logic [NUM_QUEUES-1:0]     q_full,
    output logic [NUM_QUEUES-1:0]     q_empty,
    output logic [31:0]               wr_cmd_cnt,
    output logic [31:0]               rd_cmd_cnt
);

    localparam int unsigned QA = MEM_ADDR_WIDTH - QUEUE_ID_WIDTH;
    localparam int unsigned OW = QA + 1;
    localparam int unsigned BW = $clog2(BURST_LEN + 1);
    localparam logic [OW-1:0] REGION = {1'b1, {QA{1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ} state_t;

    state_t              state;
    logic [BW-1:0]       burst;
    logic [QUEUE_ID_WIDTH-1:0] wr_rr, rd_rr;

    logic [QA-1:0] tail_q [NUM_QUEUES];
    logic [QA-1:0] head_q [NUM_QUEUES];
    logic [OW-1:0] occ_q  [NUM_QUEUES];
    logic [QA-1:0] tail_n [NUM_QUEUES];
    logic [QA-1:0] head_n [NUM_QUEUES];
    logic [OW-1:0] occ_n  [NUM_QUEUES];

    logic accept, wr_acc, rd_acc, can_load;
    logic [NUM_QUEUES-1:0] w_elig, r_elig;
    logic [QUEUE_ID_WIDTH-1:0] w_pick, r_pick;
    logic w_hit, r_hit;
    logic any_w, any_r, burst_done, sel_w, sel_r;

    // Reset in the same cycle as a handshake suppresses the acceptance.
    assign accept   = mem_cmd_valid & mem_cmd_ready & ~reset;
    assign wr_acc   = accept & mem_cmd_we;
    assign rd_acc   = accept & ~mem_cmd_we;
    assign can_load = ~mem_cmd_valid | accept;

    // Post-acceptance pointers/occupancy feed both the next load and the registers.
    always_comb begin
        for (int q = 0; q < int'(NUM_QUEUES); q++) begin
            tail_n[q] = tail_q[q];
            head_n[q] = head_q[q];
            occ_n[q]  = occ_q[q];
            if (wr_acc && mem_cmd_qid == QUEUE_ID_WIDTH'(q)) begin
                tail_n[q] = tail_q[q] + QA'(1);
                occ_n[q]  = occ_q[q] + OW'(1);
            end
            if (rd_acc && mem_cmd_qid == QUEUE_ID_WIDTH'(q)) begin
                head_n[q] = head_q[q] + QA'(1);
                occ_n[q]  = occ_q[q] - OW'(1);
            end
            w_elig[q] = cal_done & wr_req[q] & (occ_n[q] != REGION);
            r_elig[q] = cal_done & rd_req[q] & (occ_n[q] != '0);
        end
    end

    // Round-robin pick per class, searching upward from the class pointer.
    always_comb begin
        w_pick = wr_rr;
        r_pick = rd_rr;
        w_hit  = 1'b0;
        r_hit  = 1'b0;
        for (int i = 0; i < int'(NUM_QUEUES); i++) begin
            if (!w_hit && w_elig[wr_rr + QUEUE_ID_WIDTH'(i)]) begin
                w_hit  = 1'b1;
                w_pick = wr_rr + QUEUE_ID_WIDTH'(i);
            end
            if (!r_hit && r_elig[rd_rr + QUEUE_ID_WIDTH'(i)]) begin
                r_hit  = 1'b1;
                r_pick = rd_rr + QUEUE_ID_WIDTH'(i);
            end
        end
    end

    // Class choice: stay in the current class until its burst is spent and the other class wants a turn.
    always_comb begin
        any_w      = |w_elig;
        any_r      = |r_elig;
        burst_done = (burst >= BW'(BURST_LEN));
        sel_w      = 1'b0;
        sel_r      = 1'b0;
        unique case (state)
            S_WRITE: begin
                if (any_w && !(burst_done && any_r)) sel_w = 1'b1;
                else                                 sel_r = any_r;
            end
            S_READ: begin
                if (any_r && !(burst_done && any_w)) sel_r = 1'b1;
                else                                 sel_w = any_w;
            end
            default: begin
                sel_w = any_w;
                sel_r = ~any_w & any_r;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            burst         <= '0;
            wr_rr         <= '0;
            rd_rr         <= '0;
            mem_cmd_valid <= 1'b0;
            mem_cmd_we    <= 1'b0;
            mem_cmd_addr  <= '0;
            mem_cmd_qid   <= '0;
            for (int q = 0; q < int'(NUM_QUEUES); q++) begin
                tail_q[q] <= '0;
                head_q[q] <= '0;
                occ_q[q]  <= '0;
            end
        end else begin
            for (int q = 0; q < int'(NUM_QUEUES); q++) begin
                tail_q[q] <= tail_n[q];
                head_q[q] <= head_n[q];
                occ_q[q]  <= occ_n[q];
            end
            if (can_load) begin
                if (sel_w) begin
                    state         <= S_WRITE;
                    burst         <= (state == S_WRITE && !burst_done) ? burst + BW'(1) : BW'(1);
                    wr_rr         <= w_pick + QUEUE_ID_WIDTH'(1);
                    mem_cmd_valid <= 1'b1;
                    mem_cmd_we    <= 1'b1;
                    mem_cmd_qid   <= w_pick;
                    mem_cmd_addr  <= {w_pick, tail_n[w_pick]};
                end else if (sel_r) begin
                    state         <= S_READ;
                    burst         <= (state == S_READ && !burst_done) ? burst + BW'(1) : BW'(1);
                    rd_rr         <= r_pick + QUEUE_ID_WIDTH'(1);
                    mem_cmd_valid <= 1'b1;
                    mem_cmd_we    <= 1'b0;
                    mem_cmd_qid   <= r_pick;
                    mem_cmd_addr  <= {r_pick, head_n[r_pick]};
                end else begin
                    state         <= S_IDLE;
                    burst         <= '0;
                    mem_cmd_valid <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        wr_pop   = '0;
        rd_issue = '0;
        if (wr_acc) wr_pop[mem_cmd_qid]   = 1'b1;
        if (rd_acc) rd_issue[mem_cmd_qid] = 1'b1;
        for (int q = 0; q < int'(NUM_QUEUES); q++) begin
            q_full[q]  = (occ_q[q] == REGION);
            q_empty[q] = (occ_q[q] == '0);
        end
    end

`ifdef SRAM_SCHED_STATS_EN
    logic [31:0] wr_cnt_q, rd_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            if (wr_acc) wr_cnt_q <= wr_cnt_q + 32'd1;
            if (rd_acc) rd_cnt_q <= rd_cnt_q + 32'd1;
        end
    end

    assign wr_cmd_cnt = wr_cnt_q;
    assign rd_cmd_cnt = rd_cnt_q;
`else
    assign wr_cmd_cnt = 32'd0;
    assign rd_cmd_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_sram_queue_scheduler.sv
// Bench for sram_queue_scheduler: behavioural queue model checked every cycle, plus directed literal checks.
module tb_sram_queue_scheduler;

    localparam int NQ = 4;
    localparam int QW = 2;
    localparam int AW = 5;
    localparam int BL = 8;
    localparam int R  = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, cal_done, mem_cmd_ready;
    logic [NQ-1:0] wr_req, rd_req;
    logic [NQ-1:0] wr_pop, rd_issue, q_full, q_empty;
    logic          mem_cmd_valid, mem_cmd_we;
    logic [AW-1:0] mem_cmd_addr;
    logic [QW-1:0] mem_cmd_qid;
    logic [31:0]   wr_cmd_cnt, rd_cmd_cnt;

    sram_queue_scheduler #(
        .NUM_QUEUES(NQ), .QUEUE_ID_WIDTH(QW), .MEM_ADDR_WIDTH(AW), .BURST_LEN(BL)
    ) dut (
        .clk(clk), .reset(reset), .cal_done(cal_done),
        .wr_req(wr_req), .rd_req(rd_req),
        .wr_pop(wr_pop), .rd_issue(rd_issue),
        .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
        .mem_cmd_we(mem_cmd_we), .mem_cmd_addr(mem_cmd_addr), .mem_cmd_qid(mem_cmd_qid),
        .q_full(q_full), .q_empty(q_empty),
        .wr_cmd_cnt(wr_cmd_cnt), .rd_cmd_cnt(rd_cmd_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: queue occupancies and pointers, the one pending command, and the current grant run.
    int  m_occ [NQ];
    int  m_head[NQ];
    int  m_tail[NQ];
    bit  m_valid, m_we;
    int  m_q, m_addr;
    int  m_cls;   // 0 none, 1 writing, 2 reading
    int  m_run;
    int  m_wptr, m_rptr;
    int unsigned m_wcnt, m_rcnt;

    logic acc_we[$];
    int   acc_addr[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int q = 0; q < NQ; q++) begin
            m_occ[q] = 0; m_head[q] = 0; m_tail[q] = 0;
        end
        m_valid = 0; m_we = 0; m_q = 0; m_addr = 0;
        m_cls = 0; m_run = 0; m_wptr = 0; m_rptr = 0;
        m_wcnt = 0; m_rcnt = 0;
    endtask

    function automatic int first_from(input bit [NQ-1:0] v, input int start);
        for (int i = 0; i < NQ; i++)
            if (v[(start + i) % NQ]) return (start + i) % NQ;
        return -1;
    endfunction

    task automatic model_update();
        bit [NQ-1:0] ew, er;
        int cls_new, q;
        if (reset) begin
            model_reset();
            return;
        end
        if (m_valid && mem_cmd_ready) begin
            if (m_we) begin
                m_tail[m_q] = (m_tail[m_q] + 1) % R; m_occ[m_q]++; m_wcnt++;
            end else begin
                m_head[m_q] = (m_head[m_q] + 1) % R; m_occ[m_q]--; m_rcnt++;
            end
            m_valid = 0;
        end
        if (m_valid) return;
        for (int i = 0; i < NQ; i++) begin
            ew[i] = cal_done && wr_req[i] && m_occ[i] < R;
            er[i] = cal_done && rd_req[i] && m_occ[i] > 0;
        end
        // Keep the current class while it has work and its run is short or the other class is idle.
        if (m_cls == 1 && ew != 0 && (m_run < BL || er == 0))      cls_new = 1;
        else if (m_cls == 2 && er != 0 && (m_run < BL || ew == 0)) cls_new = 2;
        else if (m_cls == 1)                                        cls_new = (er != 0) ? 2 : 0;
        else if (m_cls == 2)                                        cls_new = (ew != 0) ? 1 : 0;
        else                                                        cls_new = (ew != 0) ? 1 : ((er != 0) ? 2 : 0);
        if (cls_new == 0) begin
            m_cls = 0; m_run = 0;
            return;
        end
        m_run = (cls_new == m_cls && m_run < BL) ? m_run + 1 : 1;
        m_cls = cls_new;
        m_valid = 1;
        if (cls_new == 1) begin
            q = first_from(ew, m_wptr); m_wptr = (q + 1) % NQ;
            m_we = 1; m_addr = q * R + m_tail[q];
        end else begin
            q = first_from(er, m_rptr); m_rptr = (q + 1) % NQ;
            m_we = 0; m_addr = q * R + m_head[q];
        end
        m_q = q;
    endtask

    task automatic compare_all();
        logic [NQ-1:0] e_pop, e_iss, e_full, e_empty;
        bit go;
        go = m_valid && mem_cmd_ready && !reset;
        e_pop = (go && m_we)  ? NQ'(1 << m_q) : '0;
        e_iss = (go && !m_we) ? NQ'(1 << m_q) : '0;
        for (int q = 0; q < NQ; q++) begin
            e_full[q]  = (m_occ[q] == R);
            e_empty[q] = (m_occ[q] == 0);
        end
        chk("cmd_valid", mem_cmd_valid, m_valid);
        if (m_valid) begin
            chk("cmd_we", mem_cmd_we, m_we);
            chk("cmd_addr", mem_cmd_addr, m_addr);
            chk("cmd_qid", mem_cmd_qid, m_q);
        end
        chk("wr_pop", wr_pop, e_pop);
        chk("rd_issue", rd_issue, e_iss);
        chk("q_full", q_full, e_full);
        chk("q_empty", q_empty, e_empty);
`ifdef SRAM_SCHED_STATS_EN
        chk("wr_cmd_cnt", wr_cmd_cnt, m_wcnt);
        chk("rd_cmd_cnt", rd_cmd_cnt, m_rcnt);
`else
        chk("wr_cmd_cnt", wr_cmd_cnt, 0);
        chk("rd_cmd_cnt", rd_cmd_cnt, 0);
`endif
    endtask

    // Inputs are driven at the falling edge; outputs are compared 1 time unit later.
    task automatic cycle();
        #1;
        compare_all();
        if (mem_cmd_valid && mem_cmd_ready && !reset) begin
            acc_we.push_back(mem_cmd_we);
            acc_addr.push_back(int'(mem_cmd_addr));
        end
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1; cycle(); reset = 0;
        acc_we.delete(); acc_addr.delete();
    endtask

    initial begin
        int exp_addr[3];
        int n_wr, run, runs[$];

        exp_addr[0] = 0; exp_addr[1] = 16; exp_addr[2] = 1;
        reset = 1; cal_done = 0; wr_req = '0; rd_req = '0; mem_cmd_ready = 0;
        model_reset();
        @(negedge clk);
        cycle(); cycle();
        chk("rst_valid", mem_cmd_valid, 0);
        chk("rst_addr", mem_cmd_addr, 0);
        chk("rst_empty", q_empty, 4'hF);
        chk("rst_full", q_full, 4'h0);

        // Uncalibrated memory: nothing issues
        reset = 0; wr_req = 4'hF;
        repeat (20) cycle();
        chk("nocal_valid", mem_cmd_valid, 0);
        cal_done = 1;
        cycle();
        chk("cal_first_valid", mem_cmd_valid, 1);
        chk("cal_first_we", mem_cmd_we, 1);
        chk("cal_first_addr", mem_cmd_addr, 0);
        chk("cal_first_qid", mem_cmd_qid, 0);

        // Reset while a command is pending and ready arrives with it
        repeat (2) cycle();
        reset = 1; mem_cmd_ready = 1;
        #1 chk("rst_mid_nopop", wr_pop, 0);
        cycle();
        reset = 0; wr_req = '0;
        chk("rst_mid_valid", mem_cmd_valid, 0);
        chk("rst_mid_empty", q_empty, 4'hF);
        chk("rst_mid_wcnt", wr_cmd_cnt, 0);

        // Round robin across q0/q2
        acc_we.delete(); acc_addr.delete();
        wr_req = 4'b0101;
        repeat (6) cycle();
        chk("rr_count_ok", acc_addr.size() >= 3, 1);
        for (int i = 0; i < 3 && i < acc_addr.size(); i++) begin
            chk("rr_addr", acc_addr[i], exp_addr[i]);
            chk("rr_we", acc_we[i], 1);
        end

        // Fill q1 to capacity, then read it back
        do_reset();
        wr_req = 4'b0010;
        repeat (20) cycle();
        n_wr = 0;
        foreach (acc_we[i]) if (acc_we[i]) n_wr++;
        chk("fill_writes", n_wr, 8);
        chk("fill_full", q_full, 4'b0010);
        acc_we.delete(); acc_addr.delete();
        wr_req = '0; rd_req = 4'b0010;
        repeat (4) cycle();
        chk("fill_rd_seen", acc_addr.size() > 0, 1);
        if (acc_addr.size() > 0) begin
            chk("fill_rd_addr", acc_addr[0], 8);
            chk("fill_rd_we", acc_we[0], 0);
        end

        // Contended bursts: runs of 8 per class
        do_reset();
        rd_req = '0; wr_req = 4'hF;
        repeat (16) cycle();
        acc_we.delete(); acc_addr.delete();
        rd_req = 4'hF;
        repeat (45) cycle();
        run = 1;
        for (int i = 1; i < acc_we.size(); i++) begin
            if (acc_we[i] == acc_we[i-1]) run++;
            else begin runs.push_back(run); run = 1; end
        end
        chk("burst_nruns", runs.size() >= 4, 1);
        for (int i = 1; i < runs.size(); i++)
            chk("burst_len", runs[i], 8);

        // Randomized traffic with stalls, calibration drops and occasional reset
        do_reset();
        repeat (3000) begin
            wr_req        = NQ'($urandom);
            rd_req        = NQ'($urandom);
            mem_cmd_ready = 1'($urandom_range(0, 1));
            cal_done      = ($urandom_range(0, 19) != 0);
            reset         = ($urandom_range(0, 299) == 0);
            cycle();
        end
        reset = 0;
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
